spi_slave_fsm: RTL and testbench
================================

Name: spi_slave_fsm

Overview:
- Serial front end of the SPI slave and single-port RAM subsystem. Sits directly upstream of the RAM.
- Converts MOSI frames into 10-bit parallel words with a one-cycle rx_valid strobe.
- For read-data commands, takes the RAM's tx_data/tx_valid response and serialises it onto MISO, MSB first.
- Entirely synchronous to clk: one clk cycle is one SPI bit.

Parameters:
- DATA_W, 8, RAM data width; frame width is DATA_W+2 (2-bit opcode + payload).

Ports:
- clk  in  1  system clock; every SPI bit is sampled on posedge.
- rst  in  1  synchronous, active-high reset.
- SS_n  in  1  slave select, active low; a high level ends or aborts the frame.
- MOSI  in  1  serial data in, MSB first.
- MISO  out  1  serial data out, MSB first.
- rx_data  out  DATA_W+2  parallel frame to the RAM; [9:8] is the opcode.
- rx_valid  out  1  one-cycle strobe, rx_data valid.
- tx_data  in  DATA_W  read data from the RAM.
- tx_valid  in  1  tx_data valid (single-cycle pulse).

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, rx_data=0, rx_valid=0, MISO=0, bit counter=0, rd_addr_done=0.
- Opcodes: 00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA.
- State machine states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE -> CHK_CMD when SS_n=0.
- CHK_CMD: SS_n=1 -> IDLE.
  - MOSI=0 -> WRITE.
  - MOSI=1 and !rd_addr_done -> READ_ADD.
  - MOSI=1 and rd_addr_done -> READ_DATA.
  - The MOSI bit sampled here becomes frame bit 9.
- Shifting (WRITE/READ_ADD/READ_DATA): sample one MOSI bit per cycle for bits 8..0, nine cycles.
- On the cycle after bit 0 is sampled:
  - rx_data is loaded with the frame and rx_valid=1 for exactly one cycle.
  - rx_data holds its value until the next frame completes.
- rd_addr_done: set when a READ_ADD frame completes; cleared when a READ_DATA frame completes. WRITE frames do not change it.
- WRITE/READ_ADD after frame completion: remain in state, ignore MOSI, until SS_n=1 -> IDLE.
- READ_DATA after rx_valid: wait for tx_valid.
  - On tx_valid, latch tx_data into the output shifter.
  - From the next cycle, drive MISO = tx_data[7], [6], ... [0] over 8 consecutive cycles.
  - After bit 0, drive MISO=0 until SS_n=1.
  - tx_valid while not awaiting read data is ignored.
- MISO=0 whenever not actively serialising.
- SS_n=1 in any non-IDLE state -> IDLE next cycle.
  - Mid-frame abort: partial frame discarded, no rx_valid, rd_addr_done unchanged, counter cleared, MISO=0.
  - Abort during MISO serialisation stops output immediately.
- SS_n held low after a completed frame never starts a new frame; SS_n must return high first.
- rst mid-frame overrides everything: full reset values on the next cycle.
- rx_valid is never asserted in two consecutive cycles.

Optional Feature:
- Macro: SPI_ABORT_FLAG_EN.
- Defined: extra output port frame_abort (1 bit, reset 0). It pulses high for one cycle when SS_n rises while the FSM is in CHK_CMD, mid-shift (fewer than 10 bits), or mid-MISO serialisation.
- Not defined: port absent; aborts are silent; all other behaviour identical.

Decomposition:
- Package spi_pkg:
  - state enum spi_state_e {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA}.
  - Opcode constants OP_WR_ADDR/OP_WR_DATA/OP_RD_ADDR/OP_RD_DATA.
  - FRAME_W = DATA_W+2.
- One sub-module, spi_tx_serializer: load on tx_valid, 8-bit down-counter, MISO drive, abort clear.
- The FSM and input shifter stay in spi_slave_fsm.

Test Plan:
- Reset: rst=1 for 2 cycles with SS_n=0 and MOSI toggling -> rx_valid=0, MISO=0, rx_data=0, state IDLE.
- Write address: SS_n low, MOSI frame 10'b00_1010_0101 -> one rx_valid pulse with rx_data=0x0A5, 11 cycles after SS_n fall; no MISO activity.
- Read sequence:
  - Send RD_ADDR 10'b10_0000_0011 -> rx_valid with rx_data=0x203; raise SS_n.
  - Send RD_DATA 10'b11_xxxx_xxxx -> rx_valid with rx_data[9:8]=11.
  - Respond tx_valid with tx_data=0xC3 -> MISO=1,1,0,0,0,0,1,1 on the 8 cycles after tx_valid, then 0.
- rd_addr_done toggling: two back-to-back read frames, each starting with bit 1 -> first completes as READ_ADD, second as READ_DATA; a third 1-start frame is READ_ADD again.
- Abort: SS_n raised after 5 bits of 10'b01_1111_0000 -> no rx_valid, FSM in IDLE next cycle, frame_abort pulses once (SPI_ABORT_FLAG_EN); the next full frame decodes correctly.
- Spurious tx_valid: tx_valid=1 with tx_data=0xFF during a WRITE frame -> MISO stays 0, rx_data unaffected.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } spi_state_e;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  localparam int DEF_DATA_W = 8;
  localparam int FRAME_W    = DEF_DATA_W + 2;

endpackage

// File: rtl/spi_slave_fsm_tx.sv
// MISO serialiser: loads read data, shifts it out MSB first on the following cycles.
// Returns MISO to 0 once the last bit has been shown or when clr (SS_n high) is seen.
module spi_tx_serializer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clr,
  input  logic [DATA_W-1:0] din,
  output logic              miso,
  output logic              busy
);

  localparam int CW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] sh_q, sh_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              miso_q, miso_d;

  // cnt_q counts data bits still to be shown, including the one on MISO now.
  always_comb begin
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    miso_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      miso_d = din[DATA_W-1];
      sh_d   = {din[DATA_W-2:0], 1'b0};
      cnt_d  = CW'(DATA_W);
    end else if (cnt_q > CW'(1)) begin
      miso_d = sh_q[DATA_W-1];
      sh_d   = {sh_q[DATA_W-2:0], 1'b0};
      cnt_d  = cnt_q - 1'b1;
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      miso_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      miso_q <= miso_d;
    end
  end

  assign miso = miso_q;
  assign busy = (cnt_q != '0);

endmodule

// File: rtl/spi_slave_fsm.sv
// SPI slave front end: deserialises 10-bit frames to the RAM and serialises read data back.
// Optional frame_abort pulse output when SPI_ABORT_FLAG_EN is defined.
module spi_slave_fsm
  import spi_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
`ifdef SPI_ABORT_FLAG_EN
  ,
  output logic              frame_abort
`endif
);

  localparam int            FW   = DATA_W + 2;
  localparam int            CW   = $clog2(FW);
  localparam logic [CW-1:0] LAST = CW'(FW - 2);
  localparam logic [CW-1:0] DONE = CW'(FW - 1);

  spi_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [FW-2:0]    shreg_q, shreg_d;
  logic [FW-1:0]    rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rd_done_q, rd_done_d;
  logic             wait_tx_q, wait_tx_d;
  logic             in_shift;
  logic             tx_load;
  logic             tx_busy;
`ifdef SPI_ABORT_FLAG_EN
  logic             abort_q, abort_d;
`endif

  assign in_shift = (state_q == WRITE) || (state_q == READ_ADD) || (state_q == READ_DATA);
  assign tx_load  = tx_valid && wait_tx_q && !SS_n && !tx_busy;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rd_done_d  = rd_done_q;
    wait_tx_d  = wait_tx_q && !tx_valid;
`ifdef SPI_ABORT_FLAG_EN
    abort_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!SS_n) state_d = CHK_CMD;
      end
      CHK_CMD: begin
        cnt_d   = '0;
        shreg_d = {shreg_q[FW-3:0], MOSI};
        if (!MOSI)          state_d = WRITE;
        else if (rd_done_q) state_d = READ_DATA;
        else                state_d = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: begin
        // cnt_q == DONE marks a finished frame: hold here until SS_n rises.
        if (cnt_q == LAST) begin
          rx_data_d  = {shreg_q, MOSI};
          rx_valid_d = 1'b1;
          cnt_d      = DONE;
          if (state_q == READ_ADD) rd_done_d = 1'b1;
          if (state_q == READ_DATA) begin
            rd_done_d = 1'b0;
            wait_tx_d = 1'b1;
          end
        end else if (cnt_q != DONE) begin
          shreg_d = {shreg_q[FW-3:0], MOSI};
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (SS_n && state_q != IDLE) begin
      state_d    = IDLE;
      cnt_d      = '0;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      rd_done_d  = rd_done_q;
      wait_tx_d  = 1'b0;
`ifdef SPI_ABORT_FLAG_EN
      abort_d    = (state_q == CHK_CMD) || (in_shift && cnt_q != DONE) || tx_busy;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rd_done_q  <= 1'b0;
      wait_tx_q  <= 1'b0;
`ifdef SPI_ABORT_FLAG_EN
      abort_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rd_done_q  <= rd_done_d;
      wait_tx_q  <= wait_tx_d;
`ifdef SPI_ABORT_FLAG_EN
      abort_q    <= abort_d;
`endif
    end
  end

  spi_tx_serializer #(
    .DATA_W (DATA_W)
  ) u_tx (
    .clk  (clk),
    .rst  (rst),
    .load (tx_load),
    .clr  (SS_n),
    .din  (tx_data),
    .miso (MISO),
    .busy (tx_busy)
  );

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
`ifdef SPI_ABORT_FLAG_EN
  assign frame_abort = abort_q;
`endif

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Bench for spi_slave_fsm: frame-level reference model checked every cycle plus literal checks.
module tb_spi_slave_fsm;
  import spi_pkg::*;

  logic               clk = 1'b0;
  logic               rst, SS_n, MOSI, MISO, rx_valid, tx_valid;
  logic [FRAME_W-1:0] rx_data;
  logic [7:0]         tx_data;
`ifdef SPI_ABORT_FLAG_EN
  logic               frame_abort;
`endif

  int n_chk = 0, n_fail = 0, cyc = 0, t0 = 0;
  logic last_miso;

  spi_slave_fsm #(.DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
`ifdef SPI_ABORT_FLAG_EN
    ,
    .frame_abort (frame_abort)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: frames are bit lists, read data is a queue of bits waiting for MISO.
  bit         sel, complete, rd_done, awaiting, showing;
  bit         bits[$];
  bit         mq[$];
  logic       exp_rx_valid = 1'b0, exp_miso = 1'b0, exp_abort = 1'b0;
  logic [9:0] exp_rx_data = '0;
  logic [9:0] f;

  always @(posedge clk) begin
    exp_rx_valid = 1'b0;
    exp_abort    = 1'b0;
    if (rst) begin
      sel = 0; complete = 0; rd_done = 0; awaiting = 0; showing = 0;
      bits.delete(); mq.delete();
      exp_rx_data = '0; exp_miso = 1'b0;
    end else if (SS_n) begin
      exp_abort = sel && (!complete || showing);
      sel = 0; complete = 0; awaiting = 0; showing = 0;
      bits.delete(); mq.delete();
      exp_miso = 1'b0;
    end else begin
      if (awaiting && tx_valid) begin
        for (int i = 7; i >= 0; i--) mq.push_back(tx_data[i]);
        awaiting = 0;
      end
      if (!sel) sel = 1;
      else if (!complete) begin
        bits.push_back(MOSI);
        if (bits.size() == 10) begin
          f = '0;
          for (int i = 0; i < 10; i++) f = {f[8:0], bits[i]};
          exp_rx_data  = f;
          exp_rx_valid = 1'b1;
          complete     = 1;
          if (f[9]) begin
            if (rd_done) begin rd_done = 0; awaiting = 1; end
            else rd_done = 1;
          end
        end
      end
      showing  = (mq.size() > 0);
      exp_miso = showing ? mq.pop_front() : 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      check("rx_valid", rx_valid, exp_rx_valid);
      check("rx_data", rx_data, exp_rx_data);
      check("miso", MISO, exp_miso);
`ifdef SPI_ABORT_FLAG_EN
      check("frame_abort", frame_abort, exp_abort);
`endif
    end
  end

  task automatic drive(input logic ss, input logic mosi, input logic txv, input logic [7:0] txd);
    @(negedge clk);
    last_miso = MISO;
    SS_n = ss; MOSI = mosi; tx_valid = txv; tx_data = txd;
  endtask

  // nbits of frame fr, MSB first; spur_at >= 0 pulses tx_valid=0xFF on that bit.
  task automatic send(input logic [9:0] fr, input int nbits, input int spur_at);
    logic [9:0] v;
    v = fr;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    t0 = cyc;
    for (int i = 0; i < nbits; i++) begin
      drive(1'b0, v[9], (i == spur_at), (i == spur_at) ? 8'hFF : 8'h00);
      v = {v[8:0], 1'b0};
    end
  endtask

  task automatic expect_rx(input string name, input logic [9:0] exp);
    @(negedge clk);
    check({name, "_valid"}, rx_valid, 1'b1);
    check({name, "_data"}, rx_data, exp);
  endtask

  task automatic collect_miso(input string name, input logic [7:0] exp);
    logic [7:0] b;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      b = {b[6:0], last_miso};
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    check({name, "_bits"}, b, exp);
    check({name, "_tail"}, last_miso, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    rst = 1'b1; SS_n = 1'b0; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
    for (int i = 0; i < 2; i++) drive(1'b0, 1'(i), 1'b0, 8'h00);
    @(negedge clk);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_miso", MISO, 1'b0);
    check("rst_rx_data", rx_data, 10'h000);
    rst = 1'b0; SS_n = 1'b1;
    idle(2);

    // WR_ADDR, then SS_n held low with MOSI toggling: no second frame.
    send({OP_WR_ADDR, 8'hA5}, 10, -1);
    expect_rx("wr_addr", 10'h0A5);
    check("wr_addr_latency", cyc - t0, 11);
    for (int i = 0; i < 14; i++) drive(1'b0, 1'(i), 1'b0, 8'h00);
    idle(2);

    // RD_ADDR then RD_DATA with 0xC3 response.
    send({OP_RD_ADDR, 8'h03}, 10, -1);
    expect_rx("rd_addr", 10'h203);
    idle(2);
    send({OP_RD_DATA, 8'h5A}, 10, -1);
    expect_rx("rd_data", 10'h35A);
    check("rd_data_op", rx_data[9:8], OP_RD_DATA);
    drive(1'b0, 1'b0, 1'b1, 8'hC3);
    collect_miso("miso_c3", 8'hC3);
    idle(2);

    // 1-start frames alternate READ_ADD / READ_DATA / READ_ADD.
    send(10'h2F0, 10, -1);
    expect_rx("tog_a", 10'h2F0);
    drive(1'b0, 1'b0, 1'b1, 8'h5A);
    collect_miso("tog_a_miso", 8'h00);
    idle(2);
    send(10'h3AA, 10, -1);
    expect_rx("tog_b", 10'h3AA);
    drive(1'b0, 1'b0, 1'b1, 8'h5A);
    collect_miso("tog_b_miso", 8'h5A);
    idle(2);
    send(10'h211, 10, -1);
    expect_rx("tog_c", 10'h211);
    drive(1'b0, 1'b0, 1'b1, 8'h5A);
    collect_miso("tog_c_miso", 8'h00);
    idle(2);

    // Spurious tx_valid during a WRITE frame.
    send({OP_WR_DATA, 8'h55}, 10, 4);
    expect_rx("spur", 10'h155);
    collect_miso("spur_miso", 8'h00);
    idle(2);

    // Mid-frame abort after 5 bits, then the full frame.
    send(10'h1F0, 5, -1);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    check("abort_no_valid", rx_valid, 1'b0);
    check("abort_rx_hold", rx_data, 10'h155);
`ifdef SPI_ABORT_FLAG_EN
    check("abort_pulse", frame_abort, 1'b1);
`endif
    idle(1);
    send(10'h1F0, 10, -1);
    expect_rx("post_abort", 10'h1F0);
    idle(2);

    // Abort during MISO serialisation (rd_done still set from tog_c).
    send(10'h3C3, 10, -1);
    expect_rx("rd_abort", 10'h3C3);
    drive(1'b0, 1'b0, 1'b1, 8'hFF);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    check("rd_abort_miso", MISO, 1'b0);
    idle(2);

    // Reset in the middle of a frame, then a clean frame.
    send(10'h0FF, 4, -1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; SS_n = 1'b1;
    idle(1);
    send(10'h3E7, 10, -1);
    expect_rx("post_rst", 10'h3E7);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
